// File: rtl/pulse_stretch.sv
`default_nettype none
// ============================================================================
// Module      : pulse_stretch
// Description : Turns single-cycle request pulses into fixed-width level
//               pulses (HIGH_CYC high, at least LOW_CYC low) so a slower or
//               asynchronous receiver can edge-detect them. Requests that
//               arrive while a pulse is in flight are queued, up to DEPTH.
//               Define PULSE_STRETCH_OVF_EN to get a sticky overflow flag
//               for dropped requests; otherwise ovf is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module pulse_stretch #(
    parameter int HIGH_CYC = 4,
    parameter int LOW_CYC  = 4,
    parameter int DEPTH    = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       in,
    input  logic       ovf_clr,
    output logic       out,
    output logic       busy,
    output logic [2:0] pending,
    output logic       ovf
);

    localparam logic [1:0] c_IDLE      = 2'd0;
    localparam logic [1:0] c_HIGH      = 2'd1;
    localparam logic [1:0] c_LOW       = 2'd2;
    localparam logic [7:0] c_HIGH_LOAD = 8'(HIGH_CYC - 1);
    localparam logic [7:0] c_LOW_LOAD  = 8'(LOW_CYC - 1);
    localparam logic [2:0] c_DEPTH     = 3'(DEPTH);

    logic [1:0] r_state;
    logic [7:0] r_timer;
    logic [2:0] r_pending;

    logic [1:0] w_state_nxt;
    logic [7:0] w_timer_nxt;
    logic [2:0] w_pending_nxt;
    logic       w_last_low;
    logic       w_start_eval;
    logic       w_start;
    logic       w_drop;

    // A new pulse may only be launched from IDLE or in the final LOW cycle,
    // which is what makes back-to-back pulses exactly HIGH_CYC+LOW_CYC apart.
    assign w_last_low   = (r_state == c_LOW) && (r_timer == 8'd0);
    assign w_start_eval = (r_state == c_IDLE) || w_last_low;
    assign w_start      = w_start_eval && ((r_pending != 3'd0) || in);

    // State, timer and queue register; reset is asynchronous so out drops at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= c_IDLE;
            r_timer   <= 8'd0;
            r_pending <= 3'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_timer   <= w_timer_nxt;
            r_pending <= w_pending_nxt;
        end
    end

    // Next-state, timer and queue update; requests outside start cycles are queued.
    always_comb begin
        w_state_nxt   = r_state;
        w_timer_nxt   = r_timer;
        w_pending_nxt = r_pending;
        w_drop        = 1'b0;
        if (w_start_eval) begin
            if (w_start) begin
                w_state_nxt = c_HIGH;
                w_timer_nxt = c_HIGH_LOAD;
                // A queued request is served first; a fresh request then takes
                // its place in the queue, so the count only drops when in is low.
                if ((r_pending != 3'd0) && !in) begin
                    w_pending_nxt = r_pending - 3'd1;
                end
            end else begin
                w_state_nxt = c_IDLE;
                w_timer_nxt = 8'd0;
            end
        end else if ((r_state == c_HIGH) || (r_state == c_LOW)) begin
            if (r_timer == 8'd0) begin
                // Only HIGH can reach here with an expired timer; LOW's last
                // cycle is handled as a start-evaluation cycle above.
                w_state_nxt = c_LOW;
                w_timer_nxt = c_LOW_LOAD;
            end else begin
                w_timer_nxt = r_timer - 8'd1;
            end
            if (in) begin
                if (r_pending < c_DEPTH) begin
                    w_pending_nxt = r_pending + 3'd1;
                end else begin
                    w_drop = 1'b1;
                end
            end
        end else begin
            // Unused encoding: recover to a clean idle state.
            w_state_nxt = c_IDLE;
            w_timer_nxt = 8'd0;
        end
    end

    assign out     = (r_state == c_HIGH);
    assign busy    = (r_state != c_IDLE) || (r_pending != 3'd0);
    assign pending = r_pending;

`ifdef PULSE_STRETCH_OVF_EN
    logic r_ovf;

    // Sticky overflow flag; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

    assign ovf = r_ovf;
`else
    logic w_unused;

    assign w_unused = ovf_clr ^ w_drop;
    assign ovf      = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pulse_stretch.sv
`default_nettype none
// ============================================================================
// Module      : tb_pulse_stretch
// Description : Self-checking bench for pulse_stretch. A reference model
//               tracks the edge of the most recent pulse start and the
//               number of queued requests, and derives out/busy/pending/ovf
//               from elapsed-cycle arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pulse_stretch;

    localparam int H = 4;
    localparam int L = 4;
    localparam int D = 4;

    logic       r_clk     = 1'b0;
    logic       r_reset_n = 1'b0;
    logic       r_in      = 1'b0;
    logic       r_ovf_clr = 1'b0;
    logic       w_out;
    logic       w_busy;
    logic [2:0] w_pending;
    logic       w_ovf;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    int cyc     = 0;
    int m_start = -1000;
    int m_pend  = 0;
    int m_ovf   = 0;

    pulse_stretch #(
        .HIGH_CYC (H),
        .LOW_CYC  (L),
        .DEPTH    (D)
    ) u_dut (
        .clk     (r_clk),
        .reset_n (r_reset_n),
        .in      (r_in),
        .ovf_clr (r_ovf_clr),
        .out     (w_out),
        .busy    (w_busy),
        .pending (w_pending),
        .ovf     (w_ovf)
    );

    always #5 r_clk = ~r_clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_start = -1000;
        m_pend  = 0;
        m_ovf   = 0;
    endtask

    // One rising edge of the model: starts happen only once a full
    // HIGH+LOW period has elapsed since the previous start.
    task automatic model_edge(input logic iv, input logic cv);
        bit drop;
        drop = 1'b0;
        if (cyc - m_start >= H + L) begin
            if (m_pend > 0 || iv) begin
                m_start = cyc;
                if (m_pend > 0 && !iv) m_pend--;
            end
        end else if (iv) begin
            if (m_pend < D) m_pend++;
            else            drop = 1'b1;
        end
`ifdef PULSE_STRETCH_OVF_EN
        if (drop)    m_ovf = 1;
        else if (cv) m_ovf = 0;
`else
        if (drop || cv) m_ovf = 0;
`endif
    endtask

    task automatic check_all(input string tag);
        check({tag, ".out"},     32'(w_out),     32'((cyc - m_start) < H));
        check({tag, ".busy"},    32'(w_busy),    32'(((cyc - m_start) < H + L) || (m_pend > 0)));
        check({tag, ".pending"}, 32'(w_pending), 32'(m_pend));
        check({tag, ".ovf"},     32'(w_ovf),     32'(m_ovf));
    endtask

    task automatic step(input logic iv, input logic cv, input string tag);
        r_in      = iv;
        r_ovf_clr = cv;
        @(posedge r_clk);
        cyc++;
        model_edge(iv, cv);
        #1;
        r_in      = 1'b0;
        r_ovf_clr = 1'b0;
        check_all(tag);
    endtask

    int pulses;
    logic prev_out;

    initial begin
        // reset state while reset is held
        #1;
        check_all("reset");
        repeat (3) @(posedge r_clk);
        #1;
        check_all("reset_hold");
        r_reset_n = 1'b1;

        // single pulse, then let it drain
        repeat (5) step(1'b0, 1'b0, "idle");
        step(1'b1, 1'b0, "single");
        repeat (12) step(1'b0, 1'b0, "single");

        // three back-to-back requests
        repeat (3) step(1'b1, 1'b0, "burst3");
        repeat (28) step(1'b0, 1'b0, "burst3");

        // request exactly in the last LOW cycle: no idle gap
        step(1'b1, 1'b0, "lastlow");
        repeat (H + L - 1) step(1'b0, 1'b0, "lastlow");
        step(1'b1, 1'b0, "lastlow");
        repeat (14) step(1'b0, 1'b0, "lastlow");

        // queue overflow: six consecutive requests, then drop+clear, clear
        pulses   = 0;
        prev_out = w_out;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b0, "ovf");
            if (w_out && !prev_out) pulses++;
            prev_out = w_out;
        end
        step(1'b1, 1'b1, "ovf_setwins");
        if (w_out && !prev_out) pulses++;
        prev_out = w_out;
        step(1'b0, 1'b1, "ovf_clr");
        if (w_out && !prev_out) pulses++;
        prev_out = w_out;
        for (int i = 0; i < 50; i++) begin
            step(1'b0, 1'b0, "ovf_drain");
            if (w_out && !prev_out) pulses++;
            prev_out = w_out;
        end
        check("ovf_pulse_count", 32'(pulses), 32'd5);

        // asynchronous reset in the second HIGH cycle with three queued
        repeat (4) step(1'b1, 1'b0, "arst_fill");
        repeat (4) step(1'b0, 1'b0, "arst_fill");
        step(1'b1, 1'b0, "arst_fill");
        step(1'b0, 1'b0, "arst_fill");
        check("arst_pre_pending", 32'(w_pending), 32'd3);
        check("arst_pre_out", 32'(w_out), 32'd1);
        #2;
        r_reset_n = 1'b0;
        model_reset();
        #1;
        check("arst_out", 32'(w_out), 32'd0);
        check("arst_busy", 32'(w_busy), 32'd0);
        check("arst_pending", 32'(w_pending), 32'd0);
        check_all("arst");
        #2;
        r_reset_n = 1'b1;
        repeat (20) step(1'b0, 1'b0, "arst_after");

        // randomized traffic at several request densities
        for (int p = 0; p < 3; p++) begin
            int dens;
            dens = (p == 0) ? 10 : (p == 1) ? 35 : 80;
            for (int i = 0; i < 250; i++) begin
                step(logic'($urandom_range(99) < dens),
                     logic'($urandom_range(99) < 15), "rand");
            end
            repeat (50) step(1'b0, 1'b0, "rand_drain");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pulse_stretch.md
PULSE_STRETCH -- requirements
Module: pulse_stretch

Interface
REQ-001 The block SHALL have one clock, clk, and an asynchronous, active-low reset, reset_n.
REQ-002 Parameter HIGH_CYC, default 4: out high width in clk cycles; legal range 1..255.
REQ-003 Parameter LOW_CYC, default 4: minimum out low gap after each pulse in clk cycles; legal range 1..255.
REQ-004 Parameter DEPTH, default 4: maximum queued pulses; legal range 1..7.
REQ-005 Ports (name, direction, width, meaning), in this order, one per line:
  clk  input  1  rising-edge clock
  reset_n  input  1  asynchronous active-low reset
  in  input  1  single-cycle request pulse, sampled every rising edge
  ovf_clr  input  1  clears the overflow flag
  out  output  1  stretched level pulse for a slower or asynchronous receiver's edge detector
  busy  output  1  state != IDLE or pending != 0
  pending  output  3  count of accepted requests not yet started
  ovf  output  1  sticky overflow flag

Function
REQ-006 The state machine SHALL have three states: IDLE, HIGH and LOW; out SHALL be 1 only in HIGH.
REQ-007 An 8-bit timer SHALL count cycles in HIGH and LOW.
REQ-008 Start condition, evaluated in IDLE and in the last LOW cycle: start = (pending != 0) | in.
REQ-009 On start, the state SHALL go to HIGH and the timer SHALL load HIGH_CYC-1.
REQ-010 On start, the pending/in update SHALL be:
  - pending != 0 and in = 1: pending unchanged
  - pending != 0 and in = 0: pending decrements
  - pending = 0 and in = 1: in is consumed directly and pending stays 0
REQ-011 In IDLE with no start condition, the state SHALL stay IDLE.
REQ-012 Latency: in sampled high at edge n in IDLE SHALL drive out high for exactly the HIGH_CYC cycles following edge n.
REQ-013 HIGH SHALL go to LOW when the timer reaches 0, loading LOW_CYC-1.
REQ-014 LOW SHALL go to HIGH on a start condition in its last cycle; otherwise it SHALL go to IDLE.
REQ-015 Consecutive pulses SHALL therefore have a period of exactly HIGH_CYC+LOW_CYC cycles.
REQ-016 In HIGH and non-final LOW cycles: in=1 SHALL increment pending if pending < DEPTH; otherwise the request is dropped.
REQ-017 A request SHALL also be dropped if pending = DEPTH at a start cycle with no dequeue possible; since a start always dequeues or consumes directly, this is unreachable.
REQ-018 pending SHALL never exceed DEPTH and SHALL never wrap below 0.
REQ-019 busy SHALL be combinational from state and pending.

Reset
REQ-020 While reset_n = 0 (asynchronous), the block SHALL force: state IDLE, timer 0, pending 0, out 0, busy 0, ovf 0.
REQ-021 Reset asserted mid-HIGH SHALL drop out to 0 without waiting for a clock edge; queued requests SHALL be discarded.
REQ-022 The first edge after reset_n deasserts SHALL sample in normally.

Configuration
REQ-023 Macro PULSE_STRETCH_OVF_EN SHALL select overflow reporting.
REQ-024 With PULSE_STRETCH_OVF_EN defined:
  - a dropped request SHALL set ovf at the next edge
  - ovf_clr=1 SHALL clear ovf
  - a drop and ovf_clr in the same cycle: set wins
REQ-025 Without PULSE_STRETCH_OVF_EN: ovf SHALL be tied to 0, ovf_clr SHALL be ignored, and drops SHALL be silent.

Verification (defaults HIGH_CYC=4, LOW_CYC=4, DEPTH=4)
REQ-026 Single in pulse at edge 10 -> out=1 in cycles 11..14 and 0 from 15; busy=1 in cycles 11..18 and 0 at 19; pending stays 0.
REQ-027 in pulses at edges 10,11,12 -> out pulses start at cycles 11, 19, 27; pending goes 1 then 2, then 1 at edge 18, then 0 at edge 26.
REQ-028 in held for 6 consecutive edges, 10..15 -> pending reaches 4 at edge 14; edge-15 request dropped; ovf=1 from cycle 16 (macro defined); exactly 5 out pulses.
REQ-029 in pulse exactly on the last LOW cycle with pending=0 -> next HIGH starts with no IDLE gap; pending stays 0; period 8.
REQ-030 reset_n low in the 2nd HIGH cycle with pending=3 -> out, busy and pending go to 0 immediately; no further pulses after release.
REQ-031 ovf=1 with ovf_clr=1 and a simultaneous dropped request -> ovf stays 1; ovf_clr alone next cycle -> ovf=0.
